// File: rtl/int_priority_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// int_pkg
//   Shared constants and types for the interrupt priority controller.
//   VEC_*        : 6-bit vector indices presented on IntAddrLSBs.
//                  The CPU vector address is {9'h1FF, IntAddrLSBs, 1'b0}.
//   int_state_t  : handshake FSM state encoding (IDLE, REQ, ACK).
// ---------------------------------------------------------------------------
package int_pkg;

   localparam int VEC_RESET    = 63;  // reserved for reset, never driven here
   localparam int VEC_NMI      = 62;
   localparam int VEC_SRC_BASE = 61;  // source i -> index VEC_SRC_BASE - i

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      ACK  = 2'd2
   } int_state_t;

endpackage

// File: rtl/int_priority_ctrl_if.sv
// ---------------------------------------------------------------------------
// int_priority_ctrl_if
//   CPU-side interrupt handshake bundle.
//   NMI, INT     : request lines, driven by the controller (registered).
//   IntAddrLSBs  : vector index, driven by the controller (registered).
//   INTACK       : acknowledge, driven by the CPU.
//
// Handshake: the controller raises exactly one of NMI/INT together with a
// valid IntAddrLSBs. Until INTACK is sampled high the controller may replace
// the vector with a higher-priority one or withdraw the request. Once INTACK
// is sampled high the request line drops on the same edge and IntAddrLSBs
// stays frozen until the edge that samples INTACK low. No new request is
// raised earlier than one cycle after that edge.
//
//   master : controller side
//   slave  : CPU side
// ---------------------------------------------------------------------------
interface int_priority_ctrl_if;

   logic       NMI;
   logic       INT;
   logic [5:0] IntAddrLSBs;
   logic       INTACK;

   modport master (
      output NMI,
      output INT,
      output IntAddrLSBs,
      input  INTACK
   );

   modport slave (
      input  NMI,
      input  INT,
      input  IntAddrLSBs,
      output INTACK
   );

endinterface

// File: rtl/int_prio_enc.sv
// ---------------------------------------------------------------------------
// int_prio_enc
//   Combinational fixed-priority encoder; bit 0 is the highest priority.
//   Parameters : N_SRC  number of request bits (1..61)
//   Inputs     : pending, enable  (a request is pending & enable)
//   Outputs    : valid  at least one request present
//                idx    index of the lowest set request bit (0 when !valid)
// ---------------------------------------------------------------------------
module int_prio_enc #(
   parameter int N_SRC = 16
) (
   input  logic [N_SRC-1:0] pending,
   input  logic [N_SRC-1:0] enable,
   output logic             valid,
   output logic [5:0]       idx
);

   logic [N_SRC-1:0] req;

   assign req = pending & enable;

   // Scan from the top so the lowest set bit is the last to write idx.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (req[i]) begin
            valid = 1'b1;
            idx   = 6'(i);
         end
      end
   end

endmodule

// File: rtl/int_priority_ctrl.sv
// ---------------------------------------------------------------------------
// int_priority_ctrl
//   Interrupt arbiter/sequencer between peripheral sources and the CPU.
//   Latches rising edges of nmi_src / irq_src, arbitrates (NMI first, then
//   the lowest enabled pending source), presents the vector to the CPU and
//   clears the serviced request on acknowledge.
//
//   Ports
//     MCLK       in   master clock, rising edge
//     reset      in   synchronous, active-high
//     nmi_src    in   non-maskable request, rising edge latched
//     irq_src    in   [N_SRC] maskable requests, rising edge latched per bit
//     irq_en     in   [N_SRC] per-source enable (arbitration mask only)
//     irq_clr    in   [N_SRC] one-cycle clear strobes for pending bits
//     pending    out  [N_SRC] pending register (status readback)
//     state_dbg  out  current FSM state
//     cpu        master modport: NMI, INT, IntAddrLSBs out; INTACK in
// ---------------------------------------------------------------------------
module int_priority_ctrl
   import int_pkg::*;
#(
   parameter int N_SRC = 16
) (
   input  logic                 MCLK,
   input  logic                 reset,
   input  logic                 nmi_src,
   input  logic [N_SRC-1:0]     irq_src,
   input  logic [N_SRC-1:0]     irq_en,
   input  logic [N_SRC-1:0]     irq_clr,
   output logic [N_SRC-1:0]     pending,
   output int_state_t           state_dbg,
   int_priority_ctrl_if.master  cpu
);

   int_state_t       state, state_d;
   logic             nmi_q, nmi_d;
   logic             int_q, int_d;
   logic [5:0]       addr_q, addr_d;
   logic             ack_fire;

   logic             nmi_prev, nmi_pend;
   logic [N_SRC-1:0] irq_prev;
   logic             nmi_rise;
   logic [N_SRC-1:0] irq_rise;

   logic             enc_valid;
   logic [5:0]       enc_idx;
   logic             cand_valid;
   logic [5:0]       cand_vec;

   logic [5:0]       ack_src_idx;
   logic [N_SRC-1:0] ack_mask;
   logic             ack_nmi;

   assign nmi_rise = nmi_src & ~nmi_prev;
   assign irq_rise = irq_src & ~irq_prev;

   int_prio_enc #(.N_SRC(N_SRC)) u_enc (
      .pending (pending),
      .enable  (irq_en),
      .valid   (enc_valid),
      .idx     (enc_idx)
   );

   assign cand_valid = nmi_pend | enc_valid;
   assign cand_vec   = nmi_pend ? 6'(VEC_NMI) : (6'(VEC_SRC_BASE) - enc_idx);

   // ---------------- FSM: next state and registered-output values ----------
   always_comb begin
      state_d  = state;
      nmi_d    = nmi_q;
      int_d    = int_q;
      addr_d   = addr_q;
      ack_fire = 1'b0;
      unique case (state)
         IDLE: begin
            // INTACK here is ignored
            if (cand_valid) begin
               state_d = REQ;
               nmi_d   = nmi_pend;
               int_d   = ~nmi_pend;
               addr_d  = cand_vec;
            end
         end
         REQ: begin
            if (cpu.INTACK) begin
               state_d  = ACK;
               ack_fire = 1'b1;
               nmi_d    = 1'b0;
               int_d    = 1'b0;
            end else if (cand_valid) begin
               // Re-arbitrate: a higher-priority arrival replaces the vector
               nmi_d  = nmi_pend;
               int_d  = ~nmi_pend;
               addr_d = cand_vec;
            end else begin
               // Request withdrawn; vector keeps its last value
               state_d = IDLE;
               nmi_d   = 1'b0;
               int_d   = 1'b0;
            end
         end
         ACK: begin
            if (!cpu.INTACK) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            nmi_d   = 1'b0;
            int_d   = 1'b0;
         end
      endcase
   end

   // ---------------- acknowledge clear of the presented vector ------------
   // NMI_q is still high on the acknowledging edge, so it tells us whether
   // the presented vector was the NMI or a maskable source.
   assign ack_nmi     = ack_fire & nmi_q;
   assign ack_src_idx = 6'(VEC_SRC_BASE) - addr_q;

   always_comb begin
      ack_mask = '0;
      for (int i = 0; i < N_SRC; i++) begin
         ack_mask[i] = ack_fire & ~nmi_q & (ack_src_idx == 6'(i));
      end
   end

   // ---------------- registers --------------------------------------------
   always_ff @(posedge MCLK) begin
      if (reset) begin
         state    <= IDLE;
         nmi_q    <= 1'b0;
         int_q    <= 1'b0;
         addr_q   <= '0;
         nmi_prev <= 1'b0;
         nmi_pend <= 1'b0;
         irq_prev <= '0;
         pending  <= '0;
      end else begin
         state    <= state_d;
         nmi_q    <= nmi_d;
         int_q    <= int_d;
         addr_q   <= addr_d;
         nmi_prev <= nmi_src;
         irq_prev <= irq_src;
         // New edges win over clears on the same cycle
         nmi_pend <= (nmi_pend & ~ack_nmi) | nmi_rise;
         pending  <= (pending & ~irq_clr & ~ack_mask) | irq_rise;
      end
   end

   assign cpu.NMI         = nmi_q;
   assign cpu.INT         = int_q;
   assign cpu.IntAddrLSBs = addr_q;
   assign state_dbg       = state;

endmodule

// File: tb/tb_int_priority_ctrl.sv
// ---------------------------------------------------------------------------
// tb_int_priority_ctrl
//   Directed bench for int_priority_ctrl. Inputs change 1 time unit after a
//   rising MCLK edge; outputs are checked at the same point.
// ---------------------------------------------------------------------------
module tb_int_priority_ctrl;
   import int_pkg::*;

   localparam int N_SRC = 16;

   // ---------------- clock / reset ----------------------------------------
   logic MCLK = 1'b0;
   logic reset;
   always #5 MCLK = ~MCLK;

   logic             nmi_src;
   logic [N_SRC-1:0] irq_src;
   logic [N_SRC-1:0] irq_en;
   logic [N_SRC-1:0] irq_clr;
   logic [N_SRC-1:0] pending;
   int_state_t       state_dbg;

   int_priority_ctrl_if cpu_if ();

   int_priority_ctrl #(.N_SRC(N_SRC)) dut (
      .MCLK      (MCLK),
      .reset     (reset),
      .nmi_src   (nmi_src),
      .irq_src   (irq_src),
      .irq_en    (irq_en),
      .irq_clr   (irq_clr),
      .pending   (pending),
      .state_dbg (state_dbg),
      .cpu       (cpu_if.master)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // ---------------- driver / checker tasks -------------------------------
   task automatic step();
      @(posedge MCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Full output snapshot: INT, NMI, vector, pending, state
   task automatic chk_all(input string tag, input logic i_exp, input logic n_exp,
                          input logic [5:0] v_exp, input logic [N_SRC-1:0] p_exp,
                          input int_state_t s_exp);
      chk({tag, ".INT"},  32'(cpu_if.INT),         32'(i_exp));
      chk({tag, ".NMI"},  32'(cpu_if.NMI),         32'(n_exp));
      chk({tag, ".vec"},  32'(cpu_if.IntAddrLSBs), 32'(v_exp));
      chk({tag, ".pend"}, 32'(pending),            32'(p_exp));
      chk({tag, ".st"},   32'(state_dbg),          32'(s_exp));
   endtask

   // ---------------- directed sequence ------------------------------------
   initial begin
      reset         = 1'b1;
      nmi_src       = 1'b0;
      irq_src       = '0;
      irq_en        = 16'hFDEF;   // bits 4 and 9 disabled
      irq_clr       = '0;
      cpu_if.INTACK = 1'b0;
      step();
      step();
      chk_all("reset", 0, 0, 6'd0, 16'h0000, IDLE);
      reset = 1'b0;
      step();

      // ---- 1: src 3, latency 2, 3-cycle INTACK, vector frozen
      irq_src[3] = 1'b1;
      step();                                   // E0
      chk_all("t1_e0", 0, 0, 6'd0, 16'h0008, IDLE);
      step();                                   // E1
      chk_all("t1_e1", 1, 0, 6'd58, 16'h0008, REQ);
      cpu_if.INTACK = 1'b1;
      step();                                   // Ea
      chk_all("t1_ack1", 0, 0, 6'd58, 16'h0000, ACK);
      step();
      chk_all("t1_ack2", 0, 0, 6'd58, 16'h0000, ACK);
      step();
      chk_all("t1_ack3", 0, 0, 6'd58, 16'h0000, ACK);
      cpu_if.INTACK = 1'b0;
      step();                                   // Eb
      chk_all("t1_eb", 0, 0, 6'd58, 16'h0000, IDLE);
      step();                                   // held-high src: no new request
      chk_all("t1_held", 0, 0, 6'd58, 16'h0000, IDLE);
      irq_src = '0;
      step();

      // ---- 2: src 5 and 2 together, 2 first, gap, then 5
      irq_src = 16'h0024;
      step();
      chk_all("t2_e0", 0, 0, 6'd58, 16'h0024, IDLE);
      step();
      chk_all("t2_first", 1, 0, 6'd59, 16'h0024, REQ);
      cpu_if.INTACK = 1'b1;
      step();
      chk_all("t2_ack", 0, 0, 6'd59, 16'h0020, ACK);
      cpu_if.INTACK = 1'b0;
      step();
      chk_all("t2_gap", 0, 0, 6'd59, 16'h0020, IDLE);
      step();
      chk_all("t2_second", 1, 0, 6'd56, 16'h0020, REQ);
      cpu_if.INTACK = 1'b1;
      step();
      chk_all("t2_ack2", 0, 0, 6'd56, 16'h0000, ACK);
      cpu_if.INTACK = 1'b0;
      irq_src = '0;
      step();
      chk_all("t2_idle", 0, 0, 6'd56, 16'h0000, IDLE);

      // ---- 3: src 7 presented, NMI pre-empts, src 7 re-presented
      irq_src[7] = 1'b1;
      step();
      step();
      chk_all("t3_src7", 1, 0, 6'd54, 16'h0080, REQ);
      nmi_src = 1'b1;
      step();                                   // nmi_pend set this edge
      chk_all("t3_nmi_lat", 1, 0, 6'd54, 16'h0080, REQ);
      step();
      chk_all("t3_nmi", 0, 1, 6'd62, 16'h0080, REQ);
      cpu_if.INTACK = 1'b1;
      step();
      chk_all("t3_nmi_ack", 0, 0, 6'd62, 16'h0080, ACK);
      cpu_if.INTACK = 1'b0;
      step();
      chk_all("t3_nmi_done", 0, 0, 6'd62, 16'h0080, IDLE);
      step();
      chk_all("t3_re7", 1, 0, 6'd54, 16'h0080, REQ);
      cpu_if.INTACK = 1'b1;
      step();
      chk_all("t3_ack7", 0, 0, 6'd54, 16'h0000, ACK);
      cpu_if.INTACK = 1'b0;
      nmi_src = 1'b0;
      irq_src = '0;
      step();
      step();
      chk_all("t3_quiet", 0, 0, 6'd54, 16'h0000, IDLE);

      // ---- 4: disabled source stays pending; enable; irq_clr in REQ
      irq_src[4] = 1'b1;
      step();
      step();
      chk_all("t4_masked", 0, 0, 6'd54, 16'h0010, IDLE);
      cpu_if.INTACK = 1'b1;                     // INTACK in IDLE ignored
      step();
      chk_all("t4_ack_idle", 0, 0, 6'd54, 16'h0010, IDLE);
      cpu_if.INTACK = 1'b0;
      irq_en = 16'hFDFF;
      step();
      chk_all("t4_en", 1, 0, 6'd57, 16'h0010, REQ);
      irq_clr[4] = 1'b1;
      step();
      chk_all("t4_clr", 1, 0, 6'd57, 16'h0000, REQ);
      irq_clr = '0;
      step();
      chk_all("t4_drop", 0, 0, 6'd57, 16'h0000, IDLE);
      irq_src = '0;
      step();

      // ---- set/clear collision on disabled source 9: set wins
      irq_src[9] = 1'b1;
      step();
      chk("col_set", 32'(pending), 32'h0200);
      irq_src[9] = 1'b0;
      step();
      irq_src[9] = 1'b1;
      irq_clr[9] = 1'b1;
      step();
      chk("col_win", 32'(pending), 32'h0200);
      irq_clr[9] = 1'b1;
      irq_src[9] = 1'b0;
      step();
      chk("col_clr", 32'(pending), 32'h0000);
      irq_clr = '0;
      step();

      // ---- 5a: reset during REQ
      irq_src[6] = 1'b1;
      step();
      step();
      chk_all("t5_req", 1, 0, 6'd55, 16'h0040, REQ);
      reset   = 1'b1;
      irq_src = '0;
      step();
      chk_all("t5_rst_req", 0, 0, 6'd0, 16'h0000, IDLE);
      reset = 1'b0;
      step();
      step();
      chk_all("t5_after", 0, 0, 6'd0, 16'h0000, IDLE);

      // ---- 5b: reset during ACK
      irq_src[6] = 1'b1;
      step();
      step();
      chk_all("t5b_req", 1, 0, 6'd55, 16'h0040, REQ);
      irq_src[1] = 1'b1;                        // left pending into ACK
      cpu_if.INTACK = 1'b1;
      step();
      chk_all("t5b_ack", 0, 0, 6'd55, 16'h0002, ACK);
      reset   = 1'b1;
      irq_src = '0;
      step();
      chk_all("t5b_rst_ack", 0, 0, 6'd0, 16'h0000, IDLE);
      cpu_if.INTACK = 1'b0;
      reset = 1'b0;
      step();
      step();
      chk_all("t5b_after", 0, 0, 6'd0, 16'h0000, IDLE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/int_priority_ctrl.md
# int_priority_ctrl

Interrupt arbiter and sequencer sitting between the peripheral interrupt sources and the CPU's `NMI`, `INT`, `IntAddrLSBs` and `INTACK` pins. It latches edge-triggered requests and picks the highest-priority enabled one. It presents that source's vector to the CPU and holds it stable through the acknowledge handshake. It then clears the serviced request. GIE gating stays inside the CPU; this block never sees SR.

## Interface
- `N_SRC`, 16: number of maskable sources, 1..61.
- `MCLK`  in  1  master clock; all logic on rising edge.
- `reset`  in  1  reset reset, synchronous, active-high; clock MCLK.
- `nmi_src`  in  1  non-maskable request; rising edge latched.
- `irq_src`  in  N_SRC  maskable requests, MCLK domain; rising edge latched per bit.
- `irq_en`  in  N_SRC  per-source enable mask, from peripheral config.
- `irq_clr`  in  N_SRC  one-cycle software clear strobes for pending bits.
- `INTACK`  in  1  CPU acknowledge; high while CPU fetches the vector.
- `NMI`  out  1  to CPU; registered.
- `INT`  out  1  to CPU; registered.
- `IntAddrLSBs`  out  6  vector index; CPU vector address is {9'h1FF, IntAddrLSBs, 0}.
- `pending`  out  N_SRC  current maskable pending flags, for status readback.

## Operation
- Edge detect: one prev-register per input. A rising edge sets `pending[i]` or `nmi_pend`, whether or not the source is enabled. Disabled sources stay pending and are not arbitrated.
- Vector map:
  - Index 63 (0xFFFE) is reserved for reset and is never driven.
  - NMI uses index 62 (0xFFFC).
  - Source i uses index 61−i. Source 0 is the highest maskable priority.
- Arbitration: NMI pending has priority over everything. Otherwise the winner is the lowest i with pending[i] & irq_en[i].
- FSM states: IDLE, REQ, ACK.
  - IDLE → REQ when any candidate exists. Registers `NMI`=1 for an NMI winner, else `INT`=1. Registers `IntAddrLSBs` = winner index.
  - REQ: re-arbitrates every cycle. A newly arriving higher-priority request replaces the vector and NMI/INT before acknowledge.
  - REQ → IDLE when no candidate remains, e.g. the enable was dropped or `irq_clr` was applied. Drops `NMI`/`INT`; `IntAddrLSBs` keeps its last value.
  - REQ → ACK on `INTACK`=1. Clears the pending bit of the presented vector and drops `NMI`/`INT`. `IntAddrLSBs` is frozen.
  - ACK → IDLE on `INTACK`=0.
  - `INTACK` seen in IDLE is ignored; no state change.
- Set/clear collision: a new edge on the same cycle as an `irq_clr` or acknowledge-clear leaves the bit set; set wins.
- `reset`: state goes to IDLE and these clear to 0: `NMI`, `INT`, `IntAddrLSBs`, `pending`, `nmi_pend`, prev-registers. Reset mid-handshake abandons the handshake.

## Timing
- `irq_src[i]` is sampled high at edge E0 with prev low. After E0, `pending[i]`=1. After E1, `INT`=1 with a valid `IntAddrLSBs`. Request-to-pin latency is 2 cycles.
- `INTACK` is sampled high at edge Ea. After Ea: `INT`/`NMI`=0, pending cleared, state ACK.
- `IntAddrLSBs` must not change from the first cycle `INTACK` is high until the edge after it is sampled low.
- `INTACK` low sampled at Eb moves the FSM to IDLE. The earliest next `INT`/`NMI` is after Eb+1, giving at least one low cycle between requests.
- All outputs are registered with no combinational input-to-output paths. `pending` is the pending register itself.

## Structure
- Shared package `int_pkg`:
  - `VEC_RESET`=63, `VEC_NMI`=62, `VEC_SRC_BASE`=61.
  - FSM state typedef: IDLE, REQ, ACK.
- Sub-module `int_prio_enc`: combinational, parameter N_SRC. Inputs are pending & enable, outputs are `valid` and `idx`. It is reused by the future DMA trigger arbiter.
- Top level holds the edge detectors, pending registers, FSM and output registers.

## Test plan
- Edge on `irq_src[3]` with en[3]=1 → `INT`=1 and `IntAddrLSBs`=58 two cycles later. `INTACK` pulse for 3 cycles → `INT` drops after the first, `pending[3]`=0, vector stays at 58 throughout.
- Edges on src 5 and 2 in the same cycle, both enabled → vector 59 served first. After its ACK→IDLE, vector 56 is presented, and `INT` shows a low gap of at least 1 cycle.
- src 7 presented (vector 54); `nmi_src` edge before `INTACK` → `NMI`=1, `INT`=0, vector 62. After that ACK, src 7 is re-presented as vector 54.
- src 4 pending with en[4]=0 → no `INT` and `pending[4]`=1. Set en[4]=1 → `INT` 1 cycle later with vector 57. `irq_clr[4]` while in REQ → `INT` drops and the FSM returns to IDLE.
- `reset` during ACK, and separately during REQ → after the next edge all outputs are 0 and pending is cleared. A held-high `irq_src` creates no new request until it falls and rises again.
